// File: rtl/compositor_pkg.sv
// Shared definitions for the sprite layer compositor: default sizing,
// the colour type, the fader state encoding and small colour helpers.
package compositor_pkg;

    localparam int DEFAULT_LAYER_NUM = 8;
    localparam int DEFAULT_IDX_W     = 5;
    localparam int DEFAULT_CYCLE_LEN = 9;

    // Brightness runs 0..16 so that a full-scale multiply followed by >>4
    // reproduces the input channel exactly at level 16.
    localparam logic [4:0] LEVEL_FULL = 5'd16;
    localparam logic [4:0] LEVEL_ZERO = 5'd0;

    typedef logic [23:0] color_t;

    typedef enum logic [1:0] {
        BRIGHT   = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fader_state_t;

    // Scale one 8-bit channel by level/16; 255*16>>4 still fits in 8 bits.
    function automatic logic [7:0] scale_channel(input logic [7:0] channel,
                                                 input logic [4:0] level);
        logic [12:0] product;
        product = {5'b0, channel} * {8'b0, level};
        return product[11:4];
    endfunction

    // Scale all three channels of a colour by the same brightness level.
    function automatic color_t scale_color(input color_t color,
                                           input logic [4:0] level);
        return {scale_channel(color[23:16], level),
                scale_channel(color[15:8],  level),
                scale_channel(color[7:0],   level)};
    endfunction

endpackage

// File: rtl/sprite_palette.sv
// Combinational index-to-RGB palette ROM shared by all sprite layers.
// Entry 0 is never displayed (transparent) but holds a fixed dark grey.
module sprite_palette
    import compositor_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic [IDX_W-1:0] index,
    output color_t           color
);

    localparam int DEPTH = 2 ** IDX_W;

    // Each entry is a fixed arithmetic pattern so every index gets a
    // distinct, easily recomputed colour.
    function automatic color_t palette_entry(input int i);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        if (i == 0) begin
            return 24'h010101;
        end
        r = 8'((i * 53 + 17) % 256);
        g = 8'((i * 97 + 101) % 256);
        b = 8'((i * 29 + 200) % 256);
        return {r, g, b};
    endfunction

    color_t rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = palette_entry(i);
    end

    assign color = rom[index];

endmodule

// File: rtl/layer_compositor.sv
// Sprite layer compositor: picks the highest-priority opaque layer,
// applies per-layer palette cycling, looks the colour up in the palette,
// and fades the result through a two-stage pixel pipeline.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int LAYER_NUM = DEFAULT_LAYER_NUM,
    parameter int IDX_W     = DEFAULT_IDX_W,
    parameter int CYCLE_LEN = DEFAULT_CYCLE_LEN
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       pix_en,
    input  logic                       VGA_BLANK_N,
    input  logic                       frame_tick,
    input  logic [LAYER_NUM-1:0]       layer_hit,
    input  logic [LAYER_NUM*IDX_W-1:0] layer_index,
    input  logic [LAYER_NUM-1:0]       cycle_en,
    input  logic [23:0]                bkg_color,
    input  logic                       fade_start,
    input  logic                       fade_dir,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B,
    output logic                       fade_busy
);

    localparam logic [IDX_W-1:0] CNT_MAX   = IDX_W'(CYCLE_LEN - 1);
    localparam logic [IDX_W:0]   CYCLE_TOP = (IDX_W + 1)'(CYCLE_LEN);

    logic [IDX_W-1:0] cycle_cnt;

    fader_state_t fade_state;
    fader_state_t state_next;
    logic [4:0]   level;
    logic [4:0]   level_next;
    logic         fade_moved;

    logic             win_found;
    logic [IDX_W-1:0] win_index;
    logic             win_cycle;
    logic [IDX_W:0]   cyc_sum;
    logic [IDX_W-1:0] final_index;
    color_t           pal_color;
    color_t           sel_color;

    color_t s1_color;
    logic   s1_blank_n;

    // Frame-rate palette cycle position, advanced by frame_tick even when
    // the pixel pipeline is stalled.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_cnt <= '0;
        end else if (frame_tick) begin
            if (cycle_cnt == CNT_MAX) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + IDX_W'(1);
            end
        end
    end

    // Fader next state: an accepted fade request wins over that cycle's
    // level step, and reversals keep the current level.
    always_comb begin
        state_next = fade_state;
        level_next = level;
        fade_moved = 1'b0;
        if (fade_start) begin
            if (fade_dir && (fade_state == BRIGHT || fade_state == FADE_IN)) begin
                state_next = FADE_OUT;
                fade_moved = 1'b1;
            end else if (!fade_dir && (fade_state == DARK || fade_state == FADE_OUT)) begin
                state_next = FADE_IN;
                fade_moved = 1'b1;
            end
        end
        if (frame_tick && !fade_moved) begin
            case (fade_state)
                FADE_OUT: begin
                    if (level <= 5'd1) begin
                        level_next = LEVEL_ZERO;
                        state_next = DARK;
                    end else begin
                        level_next = level - 5'd1;
                    end
                end
                FADE_IN: begin
                    if (level >= 5'd15) begin
                        level_next = LEVEL_FULL;
                        state_next = BRIGHT;
                    end else begin
                        level_next = level + 5'd1;
                    end
                end
                default: begin
                    level_next = level;
                end
            endcase
        end
    end

    // Fader registers; reset always lands in full brightness.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fade_state <= BRIGHT;
            level      <= LEVEL_FULL;
        end else begin
            fade_state <= state_next;
            level      <= level_next;
        end
    end

    assign fade_busy = (fade_state == FADE_OUT) || (fade_state == FADE_IN);

    // Priority select: walk from the lowest priority upward so the lowest
    // opaque hit layer is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_index = '0;
        win_cycle = 1'b0;
        for (int k = LAYER_NUM - 1; k >= 0; k--) begin
            if (layer_hit[k] && (layer_index[k*IDX_W +: IDX_W] != '0)) begin
                win_found = 1'b1;
                win_index = layer_index[k*IDX_W +: IDX_W];
                win_cycle = cycle_en[k];
            end
        end
    end

    // Palette cycling rotates indices 1..CYCLE_LEN around the ring; the
    // partial sum stays below twice the ring length so one wrap suffices.
    always_comb begin
        cyc_sum     = {1'b0, win_index} + {1'b0, cycle_cnt} - (IDX_W + 1)'(1);
        final_index = win_index;
        if (win_cycle && (win_index != '0) && ({1'b0, win_index} <= CYCLE_TOP)) begin
            if (cyc_sum >= CYCLE_TOP) begin
                cyc_sum = cyc_sum - CYCLE_TOP;
            end
            final_index = cyc_sum[IDX_W-1:0] + IDX_W'(1);
        end
    end

    sprite_palette #(
        .IDX_W (IDX_W)
    ) u_palette (
        .index (final_index),
        .color (pal_color)
    );

    assign sel_color = win_found ? pal_color : bkg_color;

    // Stage 1: capture the chosen colour with its blanking flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_color   <= '0;
            s1_blank_n <= 1'b0;
        end else if (pix_en) begin
            s1_color   <= sel_color;
            s1_blank_n <= VGA_BLANK_N;
        end
    end

    // Stage 2: apply the current fade level, forcing black during blanking.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {VGA_R, VGA_G, VGA_B} <= 24'h000000;
        end else if (pix_en) begin
            if (s1_blank_n) begin
                {VGA_R, VGA_G, VGA_B} <= scale_color(s1_color, level);
            end else begin
                {VGA_R, VGA_G, VGA_B} <= 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed and randomised checks of layer_compositor against a small
// behavioural model of the compositing, cycling and fading rules.
module tb_layer_compositor;

    localparam int LAYER_NUM = 8;
    localparam int IDX_W     = 5;
    localparam int CYCLE_LEN = 9;

    logic                       Clk = 1'b0;
    logic                       Reset;
    logic                       pix_en;
    logic                       VGA_BLANK_N;
    logic                       frame_tick;
    logic [LAYER_NUM-1:0]       layer_hit;
    logic [LAYER_NUM*IDX_W-1:0] layer_index;
    logic [LAYER_NUM-1:0]       cycle_en;
    logic [23:0]                bkg_color;
    logic                       fade_start;
    logic                       fade_dir;
    logic [7:0]                 VGA_R;
    logic [7:0]                 VGA_G;
    logic [7:0]                 VGA_B;
    logic                       fade_busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: mode 0 bright, 1 fading out, 2 dark, 3 fading in.
    int          m_cnt;
    int          m_lvl;
    int          m_mode;
    logic [23:0] m_col_q;
    logic        m_blank_q;
    logic [23:0] m_out;
    logic [23:0] frozen;

    layer_compositor #(
        .LAYER_NUM (LAYER_NUM),
        .IDX_W     (IDX_W),
        .CYCLE_LEN (CYCLE_LEN)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_en      (pix_en),
        .VGA_BLANK_N (VGA_BLANK_N),
        .frame_tick  (frame_tick),
        .layer_hit   (layer_hit),
        .layer_index (layer_index),
        .cycle_en    (cycle_en),
        .bkg_color   (bkg_color),
        .fade_start  (fade_start),
        .fade_dir    (fade_dir),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .fade_busy   (fade_busy)
    );

    // Free-running 100 MHz clock.
    always #5 Clk = ~Clk;

    function automatic logic [23:0] ref_palette(input int i);
        if (i == 0) return 24'h010101;
        return {8'((i * 53 + 17) % 256), 8'((i * 97 + 101) % 256), 8'((i * 29 + 200) % 256)};
    endfunction

    function automatic logic [23:0] ref_scale(input logic [23:0] c, input int lvl);
        return {8'((int'(c[23:16]) * lvl) / 16), 8'((int'(c[15:8]) * lvl) / 16),
                8'((int'(c[7:0]) * lvl) / 16)};
    endfunction

    // Colour the current inputs should produce, given the model cycle count.
    function automatic logic [23:0] ref_pixel();
        for (int k = 0; k < LAYER_NUM; k++) begin
            int idx;
            idx = int'(layer_index[k*IDX_W +: IDX_W]);
            if (layer_hit[k] && idx != 0) begin
                if (cycle_en[k] && idx >= 1 && idx <= CYCLE_LEN)
                    idx = ((idx - 1 + m_cnt) % CYCLE_LEN) + 1;
                return ref_palette(idx);
            end
        end
        return bkg_color;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_lvl = 16; m_mode = 0;
        m_col_q = '0; m_blank_q = 1'b0; m_out = '0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        bit moved;
        if (pix_en) begin
            m_out     = m_blank_q ? ref_scale(m_col_q, m_lvl) : 24'h000000;
            m_col_q   = ref_pixel();
            m_blank_q = VGA_BLANK_N;
        end
        moved = 0;
        if (fade_start) begin
            if (fade_dir && (m_mode == 0 || m_mode == 3)) begin m_mode = 1; moved = 1; end
            else if (!fade_dir && (m_mode == 2 || m_mode == 1)) begin m_mode = 3; moved = 1; end
        end
        if (frame_tick && !moved) begin
            if (m_mode == 1) begin
                m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                if (m_lvl == 0) m_mode = 2;
            end else if (m_mode == 3) begin
                m_lvl = (m_lvl < 16) ? m_lvl + 1 : 16;
                if (m_lvl == 16) m_mode = 0;
            end
        end
        if (frame_tick) m_cnt = (m_cnt + 1) % CYCLE_LEN;
    endtask

    task automatic check_value(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed %06h expected %06h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        logic exp_busy;
        exp_busy = (m_mode == 1 || m_mode == 3);
        check_value(tag, {VGA_R, VGA_G, VGA_B}, m_out);
        compared++;
        assert (fade_busy === exp_busy) else begin
            mismatched++;
            $error("[TB] FAIL %s busy observed %0b expected %0b", tag, fade_busy, exp_busy);
        end
    endtask

    // One clock: model the edge, let the DUT take it, then check.
    task automatic apply_stimulus(input string tag);
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
        frame_tick = 1'b0;
        fade_start = 1'b0;
        check_output(tag);
    endtask

    task automatic clear_layers();
        layer_hit = '0; layer_index = '0; cycle_en = '0;
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #1;
        model_reset();
        check_output(tag);
        @(negedge Clk);
        check_output(tag);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; pix_en = 1'b0; VGA_BLANK_N = 1'b0; frame_tick = 1'b0;
        fade_start = 1'b0; fade_dir = 1'b0; bkg_color = '0;
        clear_layers();
        model_reset();
        @(negedge Clk);
        check_output("reset_state");
        Reset = 1'b0;

        // Background passes through unchanged at full brightness.
        pix_en = 1'b1; VGA_BLANK_N = 1'b1; bkg_color = 24'h123456;
        apply_stimulus("bkg_c1");
        apply_stimulus("bkg_c2");
        check_value("bkg_direct", {VGA_R, VGA_G, VGA_B}, 24'h123456);

        // Priority: layer 2 beats layer 5; transparent layer 2 lets 5 through.
        layer_hit = 8'b0010_0100;
        layer_index[2*IDX_W +: IDX_W] = 5'd3;
        layer_index[5*IDX_W +: IDX_W] = 5'd7;
        apply_stimulus("prio_c1");
        apply_stimulus("prio_c2");
        check_value("prio_layer2", {VGA_R, VGA_G, VGA_B}, ref_palette(3));
        layer_index[2*IDX_W +: IDX_W] = 5'd0;
        apply_stimulus("prio_c3");
        apply_stimulus("prio_c4");
        check_value("prio_layer5", {VGA_R, VGA_G, VGA_B}, ref_palette(7));

        // Palette cycling after three frame ticks.
        do_reset("reset_cycle");
        clear_layers();
        pix_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            apply_stimulus("cyc_tick");
        end
        pix_en = 1'b1;
        layer_hit = 8'b0000_0001; cycle_en = 8'b0000_0001;
        layer_index[0 +: IDX_W] = 5'd8;
        apply_stimulus("cyc_c1");
        apply_stimulus("cyc_c2");
        check_value("cyc_idx8", {VGA_R, VGA_G, VGA_B}, ref_palette(2));
        layer_index[0 +: IDX_W] = 5'd12;
        apply_stimulus("cyc_c3");
        apply_stimulus("cyc_c4");
        check_value("cyc_idx12", {VGA_R, VGA_G, VGA_B}, ref_palette(12));

        // Full fade out on a white background.
        do_reset("reset_fade");
        clear_layers();
        bkg_color = 24'hFFFFFF; VGA_BLANK_N = 1'b1; pix_en = 1'b1;
        fade_start = 1'b1; fade_dir = 1'b1;
        apply_stimulus("fade_start");
        for (int i = 1; i <= 8; i++) begin
            frame_tick = 1'b1;
            apply_stimulus("fade_tick");
        end
        apply_stimulus("fade_l8");
        check_value("fade_level8", {VGA_R, VGA_G, VGA_B}, 24'h7F7F7F);
        for (int i = 9; i <= 16; i++) begin
            frame_tick = 1'b1;
            apply_stimulus("fade_tick");
            if (i == 15) check_value("busy_l1", {23'b0, fade_busy}, 24'h1);
        end
        check_value("busy_dark", {23'b0, fade_busy}, 24'h0);
        apply_stimulus("fade_dark");
        check_value("fade_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);

        // Reversal coincident with a frame tick keeps level 10.
        do_reset("reset_rev");
        fade_start = 1'b1; fade_dir = 1'b1;
        apply_stimulus("rev_start");
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1;
            apply_stimulus("rev_tick");
        end
        fade_start = 1'b1; fade_dir = 1'b0; frame_tick = 1'b1;
        apply_stimulus("rev_turn");
        apply_stimulus("rev_l10");
        check_value("rev_level10", {VGA_R, VGA_G, VGA_B}, 24'h9F9F9F);
        frame_tick = 1'b1;
        apply_stimulus("rev_up");
        apply_stimulus("rev_l11");
        check_value("rev_level11", {VGA_R, VGA_G, VGA_B}, 24'hAFAFAF);

        // Blanked sprite, stalled pipeline, then reset in the middle of a fade.
        layer_hit = 8'b0000_1000; layer_index[3*IDX_W +: IDX_W] = 5'd20;
        VGA_BLANK_N = 1'b0;
        apply_stimulus("blank_c1");
        apply_stimulus("blank_c2");
        check_value("blank_black", {VGA_R, VGA_G, VGA_B}, 24'h000000);
        VGA_BLANK_N = 1'b1;
        apply_stimulus("hold_fill1");
        apply_stimulus("hold_fill2");
        frozen = m_out;
        pix_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bkg_color = 24'($urandom); layer_hit = 8'($urandom);
            frame_tick = (i == 2);
            apply_stimulus("hold");
            check_value("hold_frozen", {VGA_R, VGA_G, VGA_B}, frozen);
        end
        pix_en = 1'b1; clear_layers(); bkg_color = 24'hFFFFFF;
        fade_start = 1'b1; fade_dir = 1'b1;
        apply_stimulus("mid_start");
        for (int i = 0; i < 5; i++) begin
            frame_tick = 1'b1;
            apply_stimulus("mid_tick");
        end
        do_reset("reset_midfade");
        apply_stimulus("post_c1");
        apply_stimulus("post_c2");
        check_value("post_full", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            pix_en      = ($urandom_range(0, 3) != 0);
            frame_tick  = ($urandom_range(0, 9) == 0);
            fade_start  = ($urandom_range(0, 19) == 0);
            fade_dir    = 1'($urandom);
            VGA_BLANK_N = ($urandom_range(0, 9) != 0);
            bkg_color   = 24'($urandom);
            layer_hit   = 8'($urandom) & 8'($urandom);
            cycle_en    = 8'($urandom);
            for (int k = 0; k < LAYER_NUM; k++)
                layer_index[k*IDX_W +: IDX_W] =
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            apply_stimulus("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter LAYER_NUM, default 8: number of sprite layers; layer 0 has the highest priority.
REQ-002 Parameter IDX_W, default 5: palette index width; index 0 means transparent.
REQ-003 Parameter CYCLE_LEN, default 9: palette-cycling ring length, legal range 1..2^IDX_W-1.
REQ-004 Clk  in  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset  in  1: asynchronous, active-high reset.
REQ-006 pix_en  in  1: pixel-rate enable; the pixel pipeline SHALL advance only when it is 1.
REQ-007 VGA_BLANK_N  in  1: active-video flag, aligned with the layer inputs.
REQ-008 frame_tick  in  1: one-cycle pulse per frame; independent of pix_en.
REQ-009 layer_hit  in  LAYER_NUM: the current pixel lies inside layer k's bounding box.
REQ-010 layer_index  in  LAYER_NUM x IDX_W: palette index for each layer.
REQ-011 cycle_en  in  LAYER_NUM: enables palette cycling for layer k.
REQ-012 bkg_color  in  24: background RGB (R in bits 23:16), aligned with the layer inputs.
REQ-013 fade_start  in  1: one-cycle request to start a fade.
REQ-014 fade_dir  in  1: fade direction, sampled with fade_start; 1 = fade out, 0 = fade in.
REQ-015 VGA_R, VGA_G, VGA_B  out  8 each: registered colour outputs.
REQ-016 fade_busy  out  1: 1 while the fader is in FADE_OUT or FADE_IN.

Function
REQ-017 Winner layer: the lowest k with layer_hit[k]=1 and layer_index[k]!=0; if no such k, the pixel is background.
REQ-018 Cycle counter: range 0..CYCLE_LEN-1; steps +1 on each frame_tick; wraps from CYCLE_LEN-1 to 0.
REQ-019 Cycled index applies when the winner has cycle_en=1 and 1<=idx<=CYCLE_LEN: ((idx-1+cnt) mod CYCLE_LEN)+1.
REQ-020 Indices above CYCLE_LEN, or any index with cycle_en=0, SHALL pass through uncycled.
REQ-021 Pipeline stage 1 (on pix_en): register the selected colour (palette colour for the final index, else bkg_color) and VGA_BLANK_N.
REQ-022 Pipeline stage 2 (on pix_en): register outputs as channel*level>>4 if the delayed blank flag is 1, else 0x00.
REQ-023 Latency: exactly 2 pix_en cycles from input to output; when pix_en=0 all pipeline registers SHALL hold.
REQ-024 Brightness level: 5 bits, range 0..16; 16 is full brightness, 0 is black.
REQ-025 Fader states and transitions:
- BRIGHT: level=16.
- FADE_OUT: level -1 per frame_tick; at level 0 go to DARK.
- DARK: level=0.
- FADE_IN: level +1 per frame_tick; at level 16 go to BRIGHT.
REQ-026 fade_start with fade_dir=1 SHALL enter FADE_OUT from BRIGHT or FADE_IN, and is ignored in DARK.
REQ-027 fade_start with fade_dir=0 SHALL enter FADE_IN from DARK or FADE_OUT, and is ignored in BRIGHT.
REQ-028 A reversal SHALL continue from the current level without a jump.
REQ-029 If fade_start and frame_tick occur in the same cycle, the state change SHALL take effect and the level SHALL NOT step that cycle.
REQ-030 The level SHALL saturate at 0 and 16 and never wrap.
REQ-031 The cycle counter and fader SHALL update on frame_tick regardless of pix_en.

Reset
REQ-032 While Reset=1, outputs: VGA_R/G/B=0x00 and fade_busy=0.
REQ-033 While Reset=1, internal state: cycle counter=0, level=16, fader state BRIGHT, pipeline registers cleared with the blank flag at 0.
REQ-034 Reset asserted mid-fade SHALL return the fader to BRIGHT immediately, with no residual dimming after release.

Structure
REQ-035 Package compositor_pkg SHALL hold the fader state enum, the default parameter constants and the 24-bit colour typedef.
REQ-036 Sub-module sprite_palette SHALL be a combinational 2^IDX_W-entry index-to-RGB ROM; entry 0 = 0x010101.
REQ-037 The winner priority select SHALL be a parametrised loop, with no per-layer hand-written branches.

Verification
REQ-038 No layer hit, bkg_color=0x123456, blank_n=1, level 16 -> RGB 12/34/56 two pix_en cycles later.
REQ-039 Layer 2 idx 3 and layer 5 idx 7 both hit -> layer 2's palette colour is output; with layer 2 idx 0, layer 5's colour is output.
REQ-040 cycle_en=1, CYCLE_LEN=9, idx 8, after 3 frame_ticks -> cycled index 2; idx 12 with the same settings -> unchanged.
REQ-041 fade_start (dir=1) then 16 frame_ticks -> level steps 16..0, fade_busy falls with DARK, output 0; a white pixel at level 8 -> 0x7F per channel.
REQ-042 In FADE_OUT at level 10, fade_start (dir=0) coincident with frame_tick -> FADE_IN at level 10; the next tick gives level 11.
REQ-043 VGA_BLANK_N=0 with a hit sprite -> output 0 after 2 cycles; pix_en held low 5 cycles -> outputs frozen; Reset mid-fade -> level 16 and fade_busy=0.
